// File: rtl/rr_arb_req_bridge.sv
// Round-robin arbiter that funnels N_MASTER request ports onto one bridge slave port.
// Define RR_ARB_REQ_BRIDGE_PIPE_EN to insert a one-entry output register slice.
module rr_arb_req_bridge #(
    parameter  int N_MASTER   = 4,
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    localparam int BE_WIDTH   = DATA_WIDTH / 8,
    localparam int LOG_MASTER = $clog2(N_MASTER)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_MASTER-1:0]                 data_req_i,
    input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0] data_add_i,
    input  logic [N_MASTER-1:0]                 data_wen_i,
    input  logic [N_MASTER-1:0][DATA_WIDTH-1:0] data_wdata_i,
    input  logic [N_MASTER-1:0][BE_WIDTH-1:0]   data_be_i,
    output logic [N_MASTER-1:0]                 data_gnt_o,
    output logic                                data_req_o,
    output logic [ADDR_WIDTH-1:0]               data_add_o,
    output logic                                data_wen_o,
    output logic [DATA_WIDTH-1:0]               data_wdata_o,
    output logic [BE_WIDTH-1:0]                 data_be_o,
    output logic [N_MASTER-1:0]                 data_ID_o,
    input  logic                                data_gnt_i
);

    logic [LOG_MASTER-1:0] r_ptr;
    logic [LOG_MASTER-1:0] w_idx;
    logic [LOG_MASTER-1:0] w_win;
    logic                  w_found;
    logic [N_MASTER-1:0]   w_onehot;
    logic                  w_grant;

    // Search starts at the pointer; the pointer width makes the index wrap for free.
    always_comb begin
        // NOTE: every combinational output gets a default before the loop so no latch is inferred.
        w_found  = 1'b0;
        w_win    = r_ptr;
        w_idx    = r_ptr;
        w_onehot = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            w_idx = r_ptr + LOG_MASTER'(i);
            if (!w_found && data_req_i[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
        if (w_found) begin
            w_onehot[w_win] = 1'b1;
        end
    end

`ifdef RR_ARB_REQ_BRIDGE_PIPE_EN
    logic                  r_valid;
    logic [ADDR_WIDTH-1:0] r_add;
    logic                  r_wen;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [BE_WIDTH-1:0]   r_be;
    logic [N_MASTER-1:0]   r_id;

    // A master is accepted whenever the slice is empty or draining this cycle.
    assign w_grant = w_found && (!r_valid || data_gnt_i) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_id    <= '0;
        end else if (w_grant) begin
            r_valid <= 1'b1;
            r_id    <= w_onehot;
        end else if (data_gnt_i) begin
            r_valid <= 1'b0;
        end
    end

    // NOTE: payload registers carry no reset; r_valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_add   <= data_add_i[w_win];
            r_wen   <= data_wen_i[w_win];
            r_wdata <= data_wdata_i[w_win];
            r_be    <= data_be_i[w_win];
        end
    end

    assign data_req_o   = r_valid;
    assign data_add_o   = r_add;
    assign data_wen_o   = r_wen;
    assign data_wdata_o = r_wdata;
    assign data_be_o    = r_be;
    assign data_ID_o    = r_valid ? r_id : '0;
`else
    assign w_grant = w_found && data_gnt_i && !rst;

    assign data_req_o   = w_found;
    assign data_add_o   = data_add_i[w_win];
    assign data_wen_o   = data_wen_i[w_win];
    assign data_wdata_o = data_wdata_i[w_win];
    assign data_be_o    = data_be_i[w_win];
    assign data_ID_o    = w_onehot;
`endif

    assign data_gnt_o = w_grant ? w_onehot : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= w_win + 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_arb_req_bridge.sv
// Randomised self-checking bench for rr_arb_req_bridge against a queue-based reference model.
// Honours RR_ARB_REQ_BRIDGE_PIPE_EN the same way as the design.
module tb_rr_arb_req_bridge;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          data_req_i;
    logic [N-1:0][AW-1:0]  data_add_i;
    logic [N-1:0]          data_wen_i;
    logic [N-1:0][DW-1:0]  data_wdata_i;
    logic [N-1:0][BW-1:0]  data_be_i;
    logic [N-1:0]          data_gnt_o;
    logic                  data_req_o;
    logic [AW-1:0]         data_add_o;
    logic                  data_wen_o;
    logic [DW-1:0]         data_wdata_o;
    logic [BW-1:0]         data_be_o;
    logic [N-1:0]          data_ID_o;
    logic                  data_gnt_i;

    always #5 clk = ~clk;

    rr_arb_req_bridge #(.N_MASTER(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .data_req_i   (data_req_i),
        .data_add_i   (data_add_i),
        .data_wen_i   (data_wen_i),
        .data_wdata_i (data_wdata_i),
        .data_be_i    (data_be_i),
        .data_gnt_o   (data_gnt_o),
        .data_req_o   (data_req_o),
        .data_add_o   (data_add_o),
        .data_wen_o   (data_wen_o),
        .data_wdata_o (data_wdata_o),
        .data_be_o    (data_be_o),
        .data_ID_o    (data_ID_o),
        .data_gnt_i   (data_gnt_i)
    );

    typedef struct {
        logic [AW-1:0] add;
        logic          wen;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        int            id;
    } ent_t;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     m_ptr    = 0;
    ent_t   m_buf[$];
    bit     pend[N];
    int     s_win;
    bit     s_grant;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int winner();
        for (int k = 0; k < N; k++) begin
            if (data_req_i[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int w);
        logic [N-1:0] v = '0;
        if (w >= 0) v[w] = 1'b1;
        return v;
    endfunction

    // Compare all outputs against the model at the falling edge.
    task automatic sample(input bit chk);
        logic [N-1:0] e_gnt;
        @(negedge clk);
        s_win = winner();
`ifdef RR_ARB_REQ_BRIDGE_PIPE_EN
        s_grant = (s_win >= 0) && (m_buf.size() == 0 || data_gnt_i) && !rst;
`else
        s_grant = (s_win >= 0) && data_gnt_i && !rst;
`endif
        e_gnt = s_grant ? onehot(s_win) : '0;
        if (chk && !rst) begin
            check("gnt_o", data_gnt_o, e_gnt);
`ifdef RR_ARB_REQ_BRIDGE_PIPE_EN
            check("req_o", data_req_o, m_buf.size() != 0);
            if (m_buf.size() != 0) begin
                check("add_o",   data_add_o,   m_buf[0].add);
                check("wen_o",   data_wen_o,   m_buf[0].wen);
                check("wdata_o", data_wdata_o, m_buf[0].wdata);
                check("be_o",    data_be_o,    m_buf[0].be);
                check("id_o",    data_ID_o,    onehot(m_buf[0].id));
            end else begin
                check("id_idle", data_ID_o, '0);
            end
`else
            check("req_o", data_req_o, s_win >= 0);
            if (s_win >= 0) begin
                check("add_o",   data_add_o,   data_add_i[s_win]);
                check("wen_o",   data_wen_o,   data_wen_i[s_win]);
                check("wdata_o", data_wdata_o, data_wdata_i[s_win]);
                check("be_o",    data_be_o,    data_be_i[s_win]);
                check("id_o",    data_ID_o,    onehot(s_win));
            end else begin
                check("id_idle", data_ID_o, '0);
            end
`endif
        end
    endtask

    // Advance the model across the rising edge, then leave #1 for input changes.
    task automatic advance();
        ent_t e;
        @(posedge clk);
        if (rst) begin
            m_ptr = 0;
            m_buf.delete();
        end else begin
`ifdef RR_ARB_REQ_BRIDGE_PIPE_EN
            if (m_buf.size() != 0 && data_gnt_i) void'(m_buf.pop_front());
            if (s_grant) begin
                e.add   = data_add_i[s_win];
                e.wen   = data_wen_i[s_win];
                e.wdata = data_wdata_i[s_win];
                e.be    = data_be_i[s_win];
                e.id    = s_win;
                m_buf.push_back(e);
            end
`endif
            if (s_grant) begin
                m_ptr       = (s_win + 1) % N;
                pend[s_win] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic cycle(input bit chk);
        sample(chk);
        advance();
    endtask

    task automatic randomize_payload(input int i);
        data_add_i[i]   = $urandom();
        data_wen_i[i]   = 1'($urandom_range(0, 1));
        data_wdata_i[i] = $urandom();
        data_be_i[i]    = BW'($urandom());
    endtask

    initial begin
        rst        = 1'b1;
        data_req_i = '0;
        data_gnt_i = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            randomize_payload(i);
        end
        cycle(0);
        cycle(0);
        rst = 1'b0;

        // Reset state: idle, nothing granted.
        sample(1);
        check("rst_req_o", data_req_o, 1'b0);
        check("rst_gnt_o", data_gnt_o, '0);
        check("rst_id_o",  data_ID_o,  '0);
        advance();

        // Full contention: strict rotation starting at master 0.
        data_req_i = '1;
        data_gnt_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sample(1);
            check("rotation", data_gnt_o, onehot(i % N));
            advance();
        end

        // Lone requester master 2 with pointer at 3 keeps the pointer at 3.
        data_req_i = 4'b0100;
        cycle(1);
        sample(1);
        check("lone_m2_gnt", data_gnt_o, 4'b0100);
`ifndef RR_ARB_REQ_BRIDGE_PIPE_EN
        check("lone_m2_id", data_ID_o, 4'b0100);
`endif
        advance();
        data_req_i = 4'b1001;
        sample(1);
        check("ptr_held_3", data_gnt_o, 4'b1000);
        advance();
        data_req_i = '0;
        cycle(1);

        // Slave stalls with masters 1 and 3 waiting.
        data_req_i = 4'b1010;
        data_gnt_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample(1);
`ifdef RR_ARB_REQ_BRIDGE_PIPE_EN
            check("stall_gnt", data_gnt_o, (i == 0) ? 4'b0010 : 4'b0000);
`else
            check("stall_gnt", data_gnt_o, 4'b0000);
`endif
            advance();
        end
        data_req_i = '0;
        data_gnt_i = 1'b1;
        cycle(1);

`ifdef RR_ARB_REQ_BRIDGE_PIPE_EN
        // Streaming from master 0: one-cycle latency then one grant per cycle.
        data_req_i = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            sample(1);
            check("stream_req_o", data_req_o, i > 0);
            check("stream_gnt",   data_gnt_o, 4'b0001);
            advance();
        end
        data_req_i = '0;
        cycle(1);
`endif

        // Reset while a request is outstanding at the slave.
        data_req_i = 4'b0100;
        data_gnt_i = 1'b0;
        cycle(1);
        rst        = 1'b1;
        data_req_i = '0;
        cycle(0);
        rst = 1'b0;
        sample(1);
        check("post_rst_req_o", data_req_o, 1'b0);
        check("post_rst_gnt_o", data_gnt_o, '0);
        advance();
        data_req_i = 4'b1111;
        data_gnt_i = 1'b1;
        sample(1);
        check("post_rst_ptr0", data_gnt_o, 4'b0001);
        advance();
        data_req_i = '0;
        cycle(1);

        // Random traffic: masters hold requests until granted, random slave stalls and resets.
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int c = 0; c < 800; c++) begin
            rst        = ($urandom_range(0, 79) == 0);
            data_gnt_i = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    randomize_payload(i);
                end
                data_req_i[i] = pend[i];
            end
            cycle(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
